ps2_key_decoder: RTL and testbench

Receives the raw PS/2 keyboard clock/data lines and assembles Set-2 scan-code frames. It folds E0/F0 prefixes into single key events and delivers them to `hid` as one-cycle `key_strobe` pulses with `key_pressed`, `key_extended` and `key_code`. The block sits directly upstream of `hid`, between the board PS/2 pins and the CPC keyboard matrix. It is receive-only and never drives the PS/2 lines.

---
 rtl/ps2_key_decoder_if.sv | 11 +
 rtl/ps2_key_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Key-event bus from the PS/2 decoder to the hid block.
interface ps2_key_decoder_if;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (output key_strobe, key_pressed, key_extended, key_code, frame_err);
  modport slave  (input  key_strobe, key_pressed, key_extended, key_code, frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 receiver: conditions the raw pins, frames 11-bit words and folds
// E0/F0/E1 prefixes into single key events for hid. Never drives the pins.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_key_decoder_if.master hid
);
  localparam int          TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  F_MAX  = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  // line index 0 = clock, 1 = data
  logic [1:0]      w_raw;
  logic [1:0]      r_s1, r_s2, r_filt;
  logic [1:0][7:0] r_fcnt;
  logic            r_fclk_d;
  logic            w_fe, w_dat;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [7:0]      r_sh, w_sh_nx;
  logic            r_par, w_par_nx;
  logic [TW-1:0]   r_to, w_to_nx;
  logic            w_byte_vld, w_err;

  logic            r_ext, r_brk;
  logic [2:0]      r_skip;
  logic            r_stb, r_err, r_pressed, r_extended;
  logic [7:0]      r_code;

  assign w_raw = {ps2_data, ps2_clk};

  // 2-FF synchroniser plus per-line stability filter; a level must persist
  // for FILTER_LEN consecutive samples before the filtered line follows it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_filt   <= '1;
      r_fcnt   <= '0;
      r_fclk_d <= 1'b1;
    end else begin
      r_s1     <= w_raw;
      r_s2     <= r_s1;
      r_fclk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == F_MAX) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_fe  = r_fclk_d & ~r_filt[0];
  assign w_dat = r_filt[1];

  // frame FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sh    <= w_sh_nx;
      r_par   <= w_par_nx;
      r_to    <= w_to_nx;
    end
  end

  // frame FSM next state: advance on each fe, otherwise run the inactivity timer
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sh_nx    = r_sh;
    w_par_nx   = r_par;
    w_to_nx    = r_to;
    w_byte_vld = 1'b0;
    w_err      = 1'b0;
    if (w_fe) begin
      w_to_nx = '0;
      case (r_state)
        S_IDLE: begin
          if (!w_dat) begin
            w_state_nx = S_DATA;
            w_cnt_nx   = '0;
          end else begin
            w_err = 1'b1;
          end
        end
        S_DATA: begin
          w_sh_nx[r_cnt] = w_dat;
          w_cnt_nx       = r_cnt + 3'd1;
          if (r_cnt == 3'd7) w_state_nx = S_PAR;
        end
        S_PAR: begin
          w_par_nx   = w_dat;
          w_state_nx = S_STOP;
        end
        S_STOP: begin
          w_state_nx = S_IDLE;
          if (w_dat && (^r_sh ^ r_par)) w_byte_vld = 1'b1;
          else                          w_err      = 1'b1;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_to == TO_MAX) begin
        w_state_nx = S_IDLE;
        w_to_nx    = '0;
        w_err      = 1'b1;
      end else begin
        w_to_nx = r_to + 1'b1;
      end
    end
  end

  function automatic logic is_reply(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) ||
           (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // byte interpreter: prefix folding, Pause swallowing and registered event outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_skip     <= '0;
      r_stb      <= 1'b0;
      r_err      <= 1'b0;
      r_pressed  <= 1'b0;
      r_extended <= 1'b0;
      r_code     <= '0;
    end else begin
      r_stb <= 1'b0;
      r_err <= w_err;
      if (w_err) begin
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
        r_skip <= '0;
      end else if (w_byte_vld) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (r_sh == 8'hE1) begin
          r_skip <= 3'd7;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (r_sh == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_sh == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (!r_ext && !r_brk && is_reply(r_sh)) begin
          r_skip <= r_skip;
        end else begin
          r_code     <= r_sh;
          r_extended <= r_ext;
          r_pressed  <= ~r_brk;
          r_stb      <= 1'b1;
          r_ext      <= 1'b0;
          r_brk      <= 1'b0;
        end
      end
    end
  end

  assign hid.key_strobe   = r_stb;
  assign hid.frame_err    = r_err;
  assign hid.key_pressed  = r_pressed;
  assign hid.key_extended = r_extended;
  assign hid.key_code     = r_code;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: bit-level PS/2 stimulus, a byte-level event model
// and a per-cycle comparison of every output against it.
module tb_ps2_key_decoder;
  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;
  localparam int LAT  = FL + 3;  // raw clock fall -> registered output

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_decoder_if kif();

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .hid(kif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int n_stb = 0, n_err = 0;

  // model state (byte level) and pending expectation
  int         m_skip = 0;
  bit         m_ext = 0, m_brk = 0;
  int         exp_stb_cyc = -1, exp_err_cyc = -1;
  logic [7:0] p_code = 0;
  bit         p_pr = 0, p_ext = 0;
  logic [7:0] h_code = 0;
  bit         h_pr = 0, h_ext = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      h_code = 0; h_pr = 0; h_ext = 0;
    end else if (cyc == exp_stb_cyc) begin
      h_code = p_code; h_pr = p_pr; h_ext = p_ext;
    end
    chk("key_strobe", {7'd0, kif.key_strobe}, {7'd0, reset_n && cyc == exp_stb_cyc});
    chk("frame_err",  {7'd0, kif.frame_err},  {7'd0, reset_n && cyc == exp_err_cyc});
    chk("key_code", kif.key_code, h_code);
    chk("key_pressed",  {7'd0, kif.key_pressed},  {7'd0, h_pr});
    chk("key_extended", {7'd0, kif.key_extended}, {7'd0, h_ext});
    if (kif.key_strobe) n_stb++;
    if (kif.frame_err)  n_err++;
  end

  // byte-level interpretation of a completed frame, called at the stop-bit fall
  task automatic model_byte(input logic [7:0] b, input bit bad);
    int due;
    due = cyc + LAT;
    if (bad) begin
      exp_err_cyc = due; m_skip = 0; m_ext = 0; m_brk = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && !m_brk &&
                 (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE ||
                  b == 8'hFC || b == 8'h00 || b == 8'hFF)) begin
      m_skip = m_skip;
    end else begin
      exp_stb_cyc = due; p_code = b; p_ext = m_ext; p_pr = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  // one PS/2 bit: data set during clock high, then clock low; optional short glitch
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 10 - (FL - 1)) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ flip_par, glitch);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    model_byte(b, flip_par);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    int s0, e0;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // make 'A'
    s0 = n_stb;
    send_frame(8'h1C, 0, 0);
    chk("A_strobes", 8'(n_stb - s0), 8'd1);
    chk("A_code", kif.key_code, 8'h1C);
    chk("A_pressed", {7'd0, kif.key_pressed}, 8'd1);
    chk("A_ext", {7'd0, kif.key_extended}, 8'd0);

    // extended break
    s0 = n_stb;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    chk("EB_no_early", 8'(n_stb - s0), 8'd0);
    send_frame(8'h75, 0, 0);
    chk("EB_strobes", 8'(n_stb - s0), 8'd1);
    chk("EB_code", kif.key_code, 8'h75);
    chk("EB_pressed", {7'd0, kif.key_pressed}, 8'd0);
    chk("EB_ext", {7'd0, kif.key_extended}, 8'd1);

    // device reply ignored
    s0 = n_stb;
    send_frame(8'hFA, 0, 0);
    chk("FA_strobes", 8'(n_stb - s0), 8'd0);

    // parity error then good frame
    s0 = n_stb; e0 = n_err;
    send_frame(8'h29, 1, 0);
    chk("PE_err", 8'(n_err - e0), 8'd1);
    chk("PE_strobes", 8'(n_stb - s0), 8'd0);
    send_frame(8'h29, 0, 0);
    chk("PE_code", kif.key_code, 8'h29);
    chk("PE_pressed", {7'd0, kif.key_pressed}, 8'd1);

    // E0 prefix lost to timeout: start + 4 data bits, then silence
    send_frame(8'hE0, 0, 0);
    e0 = n_err;
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    exp_err_cyc = cyc + LAT + TO;
    m_skip = 0; m_ext = 0; m_brk = 0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (TO + 10) @(negedge clk);
    chk("TO_err", 8'(n_err - e0), 8'd1);
    send_frame(8'h16, 0, 0);
    chk("TO_code", kif.key_code, 8'h16);
    chk("TO_ext", {7'd0, kif.key_extended}, 8'd0);

    // Pause sequence swallowed
    s0 = n_stb;
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 0, 0);
    chk("PA_strobes", 8'(n_stb - s0), 8'd0);

    // glitched clock still decodes
    e0 = n_err;
    send_frame(8'h76, 0, 1);
    chk("GL_code", kif.key_code, 8'h76);
    chk("GL_err", 8'(n_err - e0), 8'd0);

    // reset mid-frame (after bit 3 of F0)
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);  // F0 low nibble is 0
    reset_n = 1'b0;
    m_skip = 0; m_ext = 0; m_brk = 0;
    @(posedge clk); #1;
    chk("RST_code", kif.key_code, 8'h00);
    chk("RST_strobe", {7'd0, kif.key_strobe}, 8'd0);
    chk("RST_err", {7'd0, kif.frame_err}, 8'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 0, 0);
    chk("RST_code2", kif.key_code, 8'h5A);
    chk("RST_pressed", {7'd0, kif.key_pressed}, 8'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
